control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer_if.sv | 40 ++++
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_control_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the datapath/memory it steers.
// Carries start/IR/mem_done in, and all bus-source, load and ALU controls out.
interface control_sequencer_if;
    logic        start;
    logic [31:0] IR;
    logic        mem_done;

    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        Cout;
    logic        MARin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zlowin;
    logic        IncPC;
    logic        Read;
    logic        Write;
    logic [15:0] R_out;
    logic [15:0] R_in;
    logic [4:0]  alu_op;
    logic        run;
    logic        illegal;

    modport master (
        input  start, IR, mem_done,
        output PCout, Zlowout, MDRout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, Zlowin, IncPC, Read, Write,
        output R_out, R_in, alu_op, run, illegal
    );

    modport slave (
        output start, IR, mem_done,
        input  PCout, Zlowout, MDRout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, Zlowin, IncPC, Read, Write,
        input  R_out, R_in, alu_op, run, illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control sequencer: fetch (T0-T2), dispatch (T3),
// execute (T4-T7). Ports: clock, clear (async, active-high), bus (master).
module control_sequencer (
    input  logic                 clock,
    input  logic                 clear,
    control_sequencer_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALTED
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t state;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       is_alu, is_imm, is_ld, is_st, is_nop, is_halt, legal;
    logic       unused_ir;

    assign op = bus.IR[31:27];
    assign ra = bus.IR[26:23];
    assign rb = bus.IR[22:19];
    assign rc = bus.IR[18:15];
    assign unused_ir = ^bus.IR[14:0];

    assign is_alu  = (op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_AND) || (op == OP_OR);
    assign is_imm  = (op == OP_ADDI) || (op == OP_LDI);
    assign is_ld   = (op == OP_LD);
    assign is_st   = (op == OP_ST);
    assign is_nop  = (op == OP_NOP);
    assign is_halt = (op == OP_HALT);
    assign legal   = is_alu || is_imm || is_ld || is_st || is_nop || is_halt;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (bus.start) state <= S_T0;
                S_T0:     state <= S_T1;
                S_T1:     if (bus.mem_done) state <= S_T2;
                S_T2:     state <= S_T3;
                S_T3: begin
                    if (is_halt)
                        state <= S_HALTED;
                    else if (is_nop || !legal)
                        state <= S_T0;
                    else
                        state <= S_T4;
                end
                S_T4:     state <= S_T5;
                S_T5:     state <= (is_ld || is_st) ? S_T6 : S_T0;
                // Load waits for memory here; store only stages data.
                S_T6: begin
                    if (!is_ld || bus.mem_done) state <= S_T7;
                end
                // Store waits for memory here; load just writes back.
                S_T7: begin
                    if (!is_st || bus.mem_done) state <= S_T0;
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Moore decode from state and IR; clear forces IDLE, hence all zeros.
    always_comb begin
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.Cout    = 1'b0;
        bus.MARin   = 1'b0;
        bus.PCin    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.Zlowin  = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.R_out   = 16'h0000;
        bus.R_in    = 16'h0000;
        bus.alu_op  = 5'b00000;
        bus.illegal = 1'b0;
        bus.run     = (state != S_IDLE) && (state != S_HALTED);

        case (state)
            S_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (!legal) begin
                    bus.illegal = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    bus.R_out = 16'h0001 << rb;
                    bus.Yin   = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu) begin
                    bus.R_out  = 16'h0001 << rc;
                    bus.Zlowin = 1'b1;
                    bus.alu_op = op;
                end else if (is_imm || is_ld || is_st) begin
                    // Effective address / immediate path uses the adder.
                    bus.Cout   = 1'b1;
                    bus.Zlowin = 1'b1;
                    bus.alu_op = OP_ADD;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (is_alu || is_imm) bus.R_in = 16'h0001 << ra;
                if (is_ld || is_st)   bus.MARin = 1'b1;
            end
            S_T6: begin
                if (is_ld) begin
                    bus.Read  = 1'b1;
                    bus.MDRin = 1'b1;
                end else if (is_st) begin
                    bus.R_out = 16'h0001 << ra;
                    bus.MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    bus.MDRout = 1'b1;
                    bus.R_in   = 16'h0001 << ra;
                end else if (is_st) begin
                    bus.Write = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle expected output
// vectors are queued by the stimulus and checked by a negedge monitor.
module tb_control_sequencer;

    logic clock;
    logic clear;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [12:0] F_PCOUT  = 13'h0001;
    localparam logic [12:0] F_ZLOUT  = 13'h0002;
    localparam logic [12:0] F_MDROUT = 13'h0004;
    localparam logic [12:0] F_COUT   = 13'h0008;
    localparam logic [12:0] F_MARIN  = 13'h0010;
    localparam logic [12:0] F_PCIN   = 13'h0020;
    localparam logic [12:0] F_MDRIN  = 13'h0040;
    localparam logic [12:0] F_IRIN   = 13'h0080;
    localparam logic [12:0] F_YIN    = 13'h0100;
    localparam logic [12:0] F_ZLIN   = 13'h0200;
    localparam logic [12:0] F_INCPC  = 13'h0400;
    localparam logic [12:0] F_READ   = 13'h0800;
    localparam logic [12:0] F_WRITE  = 13'h1000;

    localparam logic [51:0] ZERO = 52'h0;

    logic [51:0] exp_q[$];
    string       nm_q[$];
    int          checks;
    int          failures;

    function automatic logic [51:0] mk(input logic r, input logic il,
                                       input logic [12:0] f,
                                       input logic [4:0] alu,
                                       input logic [15:0] ro,
                                       input logic [15:0] ri);
        return {r, il, f, alu, ro, ri};
    endfunction

    function automatic logic [51:0] act(input logic [12:0] f);
        return mk(1'b1, 1'b0, f, 5'd0, 16'h0, 16'h0);
    endfunction

    logic [51:0] E_T0, E_T1, E_T2;
    initial begin
        E_T0 = act(F_PCOUT | F_MARIN | F_INCPC | F_ZLIN);
        E_T1 = act(F_ZLOUT | F_PCIN | F_READ | F_MDRIN);
        E_T2 = act(F_MDROUT | F_IRIN);
    end

    logic [51:0] obs;
    assign obs = {bus.run, bus.illegal,
                  bus.Write, bus.Read, bus.IncPC, bus.Zlowin, bus.Yin,
                  bus.IRin, bus.MDRin, bus.PCin, bus.MARin, bus.Cout,
                  bus.MDRout, bus.Zlowout, bus.PCout,
                  bus.alu_op, bus.R_out, bus.R_in};

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [51:0] e;
            string       n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h t=%0t", n, obs, e, $time);
            end
        end
    end

    task automatic step(input logic clr, input logic s, input logic md,
                        input logic [51:0] e, input string n);
        exp_q.push_back(e);
        nm_q.push_back(n);
        clear        = clr;
        bus.start    = s;
        bus.mem_done = md;
        @(posedge clock);
        #1;
    endtask

    task automatic begin_run(input logic [31:0] ir);
        step(1'b1, 1'b0, 1'b0, ZERO, "clear");
        step(1'b0, 1'b0, 1'b0, ZERO, "idle_hold");
        bus.IR = ir;
        step(1'b0, 1'b1, 1'b0, ZERO, "idle_start");
    endtask

    task automatic fetch(input int waits);
        step(1'b0, 1'b0, 1'b1, E_T0, "t0");
        for (int i = 0; i < waits; i++)
            step(1'b0, 1'b0, 1'b0, E_T1, "t1_wait");
        step(1'b0, 1'b0, 1'b1, E_T1, "t1");
        step(1'b0, 1'b0, 1'b1, E_T2, "t2");
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        clear        = 1'b1;
        bus.start    = 1'b0;
        bus.IR       = 32'h0;
        bus.mem_done = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // add R1,R2,R3
        begin_run(32'h18918000);
        fetch(0);
        step(0, 0, 1, mk(1, 0, F_YIN, 5'd0, 16'h0004, 16'h0), "add_t3");
        step(0, 0, 1, mk(1, 0, F_ZLIN, 5'b00011, 16'h0008, 16'h0), "add_t4");
        step(0, 0, 1, mk(1, 0, F_ZLOUT, 5'd0, 16'h0, 16'h0002), "add_t5");
        step(0, 0, 1, E_T0, "add_back_t0");

        // ld R4,C(R2) with three-cycle memory delays
        begin_run(32'h02100000);
        fetch(3);
        step(0, 0, 0, mk(1, 0, F_YIN, 5'd0, 16'h0004, 16'h0), "ld_t3");
        step(0, 0, 0, mk(1, 0, F_COUT | F_ZLIN, 5'b00011, 16'h0, 16'h0), "ld_t4");
        step(0, 0, 0, act(F_ZLOUT | F_MARIN), "ld_t5");
        step(0, 0, 0, act(F_READ | F_MDRIN), "ld_t6_wait");
        step(0, 0, 0, act(F_READ | F_MDRIN), "ld_t6_wait");
        step(0, 0, 0, act(F_READ | F_MDRIN), "ld_t6_wait");
        step(0, 0, 1, act(F_READ | F_MDRIN), "ld_t6");
        step(0, 0, 0, mk(1, 0, F_MDROUT, 5'd0, 16'h0, 16'h0010), "ld_t7");
        step(0, 0, 0, E_T0, "ld_back_t0");

        // st R5,C(R6)
        begin_run(32'h12B00000);
        fetch(0);
        step(0, 0, 1, mk(1, 0, F_YIN, 5'd0, 16'h0040, 16'h0), "st_t3");
        step(0, 0, 1, mk(1, 0, F_COUT | F_ZLIN, 5'b00011, 16'h0, 16'h0), "st_t4");
        step(0, 0, 1, act(F_ZLOUT | F_MARIN), "st_t5");
        step(0, 0, 0, mk(1, 0, F_MDRIN, 5'd0, 16'h0020, 16'h0), "st_t6");
        step(0, 0, 1, act(F_WRITE), "st_t7");
        step(0, 0, 0, E_T0, "st_back_t0");

        // unsupported opcode 10101
        begin_run(32'hA8000000);
        fetch(0);
        step(0, 0, 1, mk(1, 1, 13'h0, 5'd0, 16'h0, 16'h0), "illegal_t3");
        step(0, 0, 1, E_T0, "illegal_back_t0");

        // nop
        begin_run(32'hD0000000);
        fetch(0);
        step(0, 0, 1, act(13'h0), "nop_t3");
        step(0, 0, 1, E_T0, "nop_back_t0");

        // addi R7,R1,C
        begin_run(32'h63880000);
        fetch(0);
        step(0, 0, 1, mk(1, 0, F_YIN, 5'd0, 16'h0002, 16'h0), "addi_t3");
        step(0, 0, 1, mk(1, 0, F_COUT | F_ZLIN, 5'b00011, 16'h0, 16'h0), "addi_t4");
        step(0, 0, 1, mk(1, 0, F_ZLOUT, 5'd0, 16'h0, 16'h0080), "addi_t5");
        step(0, 0, 1, E_T0, "addi_back_t0");

        // or R15,R15,R0 (Ra=Rb, extreme register indices)
        begin_run(32'h37F80000);
        fetch(0);
        step(0, 0, 1, mk(1, 0, F_YIN, 5'd0, 16'h8000, 16'h0), "or_t3");
        step(0, 0, 1, mk(1, 0, F_ZLIN, 5'b00110, 16'h0001, 16'h0), "or_t4");
        step(0, 0, 1, mk(1, 0, F_ZLOUT, 5'd0, 16'h0, 16'h8000), "or_t5");
        step(0, 0, 1, E_T0, "or_back_t0");

        // halt: start ignored, only clear exits
        begin_run(32'hD8000000);
        fetch(0);
        step(0, 1, 1, act(13'h0), "halt_t3");
        for (int i = 0; i < 5; i++)
            step(0, 1, 1, ZERO, "halted");
        step(1, 0, 0, ZERO, "halt_clear");
        step(0, 0, 0, ZERO, "idle_after_halt");
        step(0, 1, 0, ZERO, "idle_start2");
        step(0, 0, 0, E_T0, "t0_after_halt");

        // clear in the middle of a load memory wait
        begin_run(32'h02100000);
        fetch(0);
        step(0, 0, 0, mk(1, 0, F_YIN, 5'd0, 16'h0004, 16'h0), "ld2_t3");
        step(0, 0, 0, mk(1, 0, F_COUT | F_ZLIN, 5'b00011, 16'h0, 16'h0), "ld2_t4");
        step(0, 0, 0, act(F_ZLOUT | F_MARIN), "ld2_t5");
        step(0, 0, 0, act(F_READ | F_MDRIN), "ld2_t6");
        step(1, 0, 0, ZERO, "clear_mid_t6");
        step(0, 0, 0, ZERO, "idle_after_clear");
        step(0, 1, 0, ZERO, "idle_start3");
        step(0, 0, 0, E_T0, "t0_after_clear");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge clock);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
